// File: rtl/data_memory_unit.sv
// Data memory unit: one outstanding load/store over a little-endian 32-bit word array.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being aligned.
module data_memory_unit #(
  parameter int DEPTH = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = DEPTH;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q;
  logic        req_ready_q, resp_valid_q, resp_error_q;
  logic [31:0] resp_rdata_q;
  logic        write_q, unsigned_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  // Array powers up zeroed and is deliberately left out of reset.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic [29:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic [1:0]    lane;
  logic [3:0]    byte_en;
  logic [31:0]   rd_word, shifted, wdata_lane, wr_word;
  logic          resp_error_d;
  logic [31:0]   resp_rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic          misalign;
`endif

  always_comb begin
    word_idx = addr_q[31:2];
    mem_idx  = word_idx[AW-1:0];
    in_range = {2'b00, word_idx} < DEPTH_W;
    lane     = addr_q[1:0];
    if (size_q == 2'b01) lane[0] = 1'b0;
    if (size_q == 2'b10) lane    = 2'b00;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign     = (size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    resp_error_d = (size_q == 2'b11) || !in_range || misalign;
`else
    resp_error_d = (size_q == 2'b11) || !in_range;
`endif
    rd_word = in_range ? mem_q[mem_idx] : '0;
    shifted = rd_word >> {lane, 3'b000};
    case (size_q)
      2'b00:   resp_rdata_d = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
      2'b01:   resp_rdata_d = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
      default: resp_rdata_d = rd_word;
    endcase
    if (resp_error_d || write_q) resp_rdata_d = '0;
    case (size_q)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = 4'b0011 << lane;
      default: byte_en = 4'b1111;
    endcase
    wdata_lane = wdata_q << {lane, 3'b000};
    wr_word    = rd_word;
    for (int k = 0; k < 4; k++) begin
      if (byte_en[k]) wr_word[8*k +: 8] = wdata_lane[8*k +: 8];
    end
  end

  // Reset wins over a store sitting in ACCESS.
  always_ff @(posedge clock) begin
    if (!reset && state_q == ACCESS && write_q && !resp_error_d) begin
      mem_q[mem_idx] <= wr_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            size_q      <= req_size;
            unsigned_q  <= req_unsigned;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          resp_rdata_q <= resp_rdata_d;
          resp_error_q <= resp_error_d;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 Parameter: DEPTH, 2048, number of 32-bit words in the array (any value >= 1).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  input  1  request present.
REQ-005 Port: req_ready  output  1  unit can accept a request.
REQ-006 Port: req_write  input  1  1 = store, 0 = load.
REQ-007 Port: req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 Port: req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-009 Port: req_addr  input  32  byte address.
REQ-010 Port: req_wdata  input  32  store data, right-aligned (bits [7:0] byte, [15:0] half).
REQ-011 Port: resp_valid  output  1  response present.
REQ-012 Port: resp_ready  input  1  consumer takes the response.
REQ-013 Port: resp_rdata  output  32  extended load data, 0 for stores and errors.
REQ-014 Port: resp_error  output  1  access faulted and had no memory side effect.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on an edge where state = IDLE and req_valid = 1; all request fields are captured into registers and the state moves to ACCESS.
REQ-017 In ACCESS the unit SHALL perform the array access at the next edge, load resp_rdata/resp_error and enter RESP; resp_valid rises exactly 2 edges after acceptance.
REQ-018 In RESP, resp_valid, resp_rdata and resp_error SHALL hold stable until an edge with resp_ready = 1, then return to IDLE with resp_valid = 0.
REQ-019 Word index = req_addr[31:2]; index >= DEPTH SHALL set resp_error and suppress the write.
REQ-020 Byte lanes are little-endian: byte k of a word occupies bits [8k+7:8k], k = addr[1:0].
REQ-021 Store byte SHALL write only lane addr[1:0]; store half SHALL write only lanes {2*addr[1]+1, 2*addr[1]}; store word SHALL write all lanes; other lanes keep their value.
REQ-022 Load byte/half SHALL extract the addressed lane(s) and extend to 32 bits per req_unsigned; load word returns the word unchanged.
REQ-023 req_size = 11 SHALL set resp_error and suppress the write.
REQ-024 Any error SHALL force resp_rdata = 0.
REQ-025 A load from a word written by the immediately preceding accepted store SHALL return the new data.
REQ-026 Array contents SHALL be zero at time 0 and SHALL NOT be cleared by reset.

Reset
REQ-027 Reset SHALL force state IDLE, req_ready = 1 (the next cycle), resp_valid = 0, resp_rdata = 0, resp_error = 0.
REQ-028 Reset SHALL take priority over any concurrent event: a store in ACCESS at a reset edge SHALL NOT write, and a request presented at a reset edge SHALL NOT be accepted.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN: when defined, half with addr[0] = 1 or word with addr[1:0] != 00 SHALL set resp_error with no write.
REQ-030 When DMEM_MISALIGN_TRAP_EN is undefined, misaligned addresses SHALL be silently aligned by clearing addr[0] (half) or addr[1:0] (word), and no error is raised.

Verification
REQ-031 The bench SHALL cover: store word 0xDEADBEEF to 0x10 and load word from 0x10 -> resp_rdata = 0xDEADBEEF, resp_valid 2 edges after each accept, resp_error = 0.
REQ-032 The bench SHALL cover: after REQ-031, store byte 0x5A to 0x13 and load word from 0x10 -> 0x5AADBEEF; signed byte load from 0x13 -> 0x0000005A; signed half load from 0x12 -> 0x00005AAD.
REQ-033 The bench SHALL cover: store word 0x000080FF to 0x20, signed load byte from 0x20 -> 0xFFFFFFFF; unsigned load half from 0x20 -> 0x000080FF; signed load half from 0x20 -> 0xFFFF80FF.
REQ-034 The bench SHALL cover: with DEPTH = 2048, store to 0x2000 -> resp_error = 1; subsequent load from 0x0000 -> 0 (no aliasing); req_size = 11 -> resp_error = 1.
REQ-035 The bench SHALL cover: with resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable and req_ready = 0 throughout; req_ready = 1 the cycle after the resp_ready edge.
REQ-036 The bench SHALL cover: reset asserted in ACCESS of a store 0x12345678 to 0x40 -> resp_valid = 0, and a later load from 0x40 returns 0; word load from 0x42 -> error (trap on) or 0x12345678-path data from 0x40 (trap off).
